// File: rtl/gz_result_packer.sv
// Goertzel multi-channel result packer: decimating clock-enable, per-channel capture
// with truncate/saturate formatting, and AXI4-Stream packing of all channels into one word.
module gz_result_packer #(
  parameter int NCH      = 4,
  parameter int OW       = 20,
  parameter int FW       = 16,
  parameter int SHIFT    = 4,
  parameter int OUT_W    = 128,
  parameter int DECIM    = 2,
  parameter int SYNC_ALL = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_clken,
  input  logic [NCH*2*OW-1:0]   s_axis_tdata,
  input  logic [NCH-1:0]        s_axis_tvalid,
  output logic [OUT_W-1:0]      m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  i_clr_flags,
  output logic [NCH-1:0]        o_overrun,
  output logic [NCH-1:0]        o_sat,
  output logic [15:0]           o_frame_cnt
);

  // state   | meaning
  // COLLECT | waiting for the pending set to satisfy the emit condition
  // HOLD    | word presented on m_axis, waiting for tready

  localparam int CW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TOPW = OW - SHIFT - FW + 1;
  localparam logic [CW-1:0] DECIM_LAST = CW'(DECIM - 1);
  localparam logic [FW-1:0] FMIN = {1'b1, {(FW-1){1'b0}}};
  localparam logic [FW-1:0] FMAX = {1'b0, {(FW-1){1'b1}}};

  typedef enum logic [0:0] {COLLECT, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          dcnt;
  logic [NCH-1:0]         pending;
  logic [NCH-1:0]         load_mask;
  logic [NCH-1:0]         fmt_sat;
  logic [NCH*2*FW-1:0]    fmt_word;
  logic [NCH*2*FW-1:0]    cap;
  logic [OUT_W-1:0]       packed_word;
  logic                   load;
  logic                   hshk;
  logic                   emit_ok;

  // Registered enable so it is low in reset and first pulses on the DECIM-th edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dcnt    <= '0;
      o_clken <= 1'b0;
    end else begin
      o_clken <= (dcnt == DECIM_LAST);
      dcnt    <= (dcnt == DECIM_LAST) ? '0 : dcnt + CW'(1);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [OW-1:0] x_re, x_im;
    logic [FW-1:0] y_re, y_im;
    logic          sat_re, sat_im;

    assign x_re = s_axis_tdata[k*2*OW+OW +: OW];
    assign x_im = s_axis_tdata[k*2*OW +: OW];

    // Bits above the kept field must all match the sign, otherwise clamp.
    assign sat_re = (x_re[OW-1:SHIFT+FW-1] != {TOPW{x_re[OW-1]}});
    assign sat_im = (x_im[OW-1:SHIFT+FW-1] != {TOPW{x_im[OW-1]}});
    assign y_re   = sat_re ? (x_re[OW-1] ? FMIN : FMAX) : x_re[SHIFT +: FW];
    assign y_im   = sat_im ? (x_im[OW-1] ? FMIN : FMAX) : x_im[SHIFT +: FW];

    assign fmt_word[k*2*FW +: 2*FW] = {y_re, y_im};
    assign fmt_sat[k]               = sat_re | sat_im;

    if (SHIFT > 0) begin : g_lsb
      logic unused_lsbs;
      assign unused_lsbs = ^{x_re[SHIFT-1:0], x_im[SHIFT-1:0]};
    end
  end

  always_comb begin
    packed_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (pending[k]) packed_word[k*2*FW +: 2*FW] = cap[k*2*FW +: 2*FW];
    end
  end

  assign emit_ok   = (SYNC_ALL != 0) ? (&pending) : (|pending);
  assign load_mask = load ? pending : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    hshk    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (emit_ok) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (m_axis_tvalid && m_axis_tready) begin
          hshk    = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Load reads the old capture contents, so a same-edge capture survives as pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap           <= '0;
      pending       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      o_overrun     <= '0;
      o_sat         <= '0;
      o_frame_cnt   <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (s_axis_tvalid[k]) cap[k*2*FW +: 2*FW] <= fmt_word[k*2*FW +: 2*FW];
      end
      pending   <= (pending & ~load_mask) | s_axis_tvalid;
      o_overrun <= (i_clr_flags ? '0 : o_overrun) | (s_axis_tvalid & pending & ~load_mask);
      o_sat     <= (i_clr_flags ? '0 : o_sat) | (s_axis_tvalid & fmt_sat);
      if (load) begin
        m_axis_tdata  <= packed_word;
        m_axis_tvalid <= 1'b1;
      end else if (hshk) begin
        m_axis_tvalid <= 1'b0;
      end
      if (hshk) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

endmodule
